uart_tx_framed: RTL
===================

// Module: uart_tx_framed
// PURPOSE
//  Buffered, frame-configurable UART transmitter for the IO-circuits layer.
//  Accepts bytes over a ready/valid port into a FIFO and serialises them LSB-first.
//  Frame format is set at elaboration: data bits, optional parity, and stop-bit count.
//  Sits between the CPU/MMIO UART registers and the board TX pin.
//  Transmits back-to-back frames with no idle gap.
// PARAMETERS
//  CLOCK_FREQ   125_000_000  system clock in Hz
//  BAUD_RATE    115_200      line rate; SYMBOL_EDGE_TIME = CLOCK_FREQ/BAUD_RATE clocks per bit (must be >= 2)
//  DATA_BITS    8            payload bits per frame, 5..9
//  PARITY       0            0 = none, 1 = odd, 2 = even
//  STOP_BITS    1            1 or 2
//  FIFO_DEPTH   4            entries; power of two, >= 2
// PORTS
//  clk            in   1                          system clock
//  reset          in   1                          synchronous, active-high
//  data_in        in   DATA_BITS                  payload word
//  data_in_valid  in   1                          producer has a word
//  data_in_ready  out  1                          FIFO not full
//  serial_out     out  1                          TX line; idle high
//  tx_busy        out  1                          shifter is mid-frame
//  fifo_count     out  $clog2(FIFO_DEPTH+1)       number of words queued (excludes word in shifter)
// BEHAVIOUR
//  Reset values: serial_out=1, tx_busy=0, fifo_count=0, data_in_ready=1.
//   FSM returns to IDLE; FIFO pointers are cleared.
//  Handshake
//   - A push occurs on each edge with data_in_valid && data_in_ready.
//   - data_in_ready = (fifo_count != FIFO_DEPTH), derived from the registered count.
//   - A push and a pop on the same edge leave fifo_count unchanged.
//   - When full, no push is accepted that cycle, even if a pop occurs.
//  FSM states: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE or START.
//   - IDLE, fifo_count != 0 at an edge: pop the head word into the shift register; go to START.
//   - Each bit lasts exactly SYMBOL_EDGE_TIME clocks, timed by a bit counter that resets on every state change.
//   - DATA: sends bit 0 through bit DATA_BITS-1 of the word.
//   - PARITY (only when PARITY != 0): sends the XOR of the data bits (even) or its inverse (odd).
//   - STOP: sends STOP_BITS bit-times of 1.
//   - Last clock of STOP with FIFO non-empty: pop, then go directly to START (zero idle clocks).
//   - Last clock of STOP with FIFO empty: go to IDLE.
//  Output registers
//   - serial_out is registered: START=0, DATA=shift bit, PARITY=parity bit, STOP and IDLE=1.
//   - tx_busy = 1 in every state except IDLE.
//  Latency: push at edge N into an empty FIFO with an idle shifter.
//   - fifo_count=1 after edge N.
//   - Pop occurs at edge N+1; serial_out goes low after edge N+1.
//  Frame length
//   - FRAME = 1 + DATA_BITS + (PARITY != 0) + STOP_BITS bit-times.
//   - Total clocks per frame = FRAME * SYMBOL_EDGE_TIME.
//  Width: the bit counter is $clog2(SYMBOL_EDGE_TIME) wide. The data-bit index wraps only via a state change, never arithmetically.
//  Reset mid-frame: the frame is aborted and queued words are discarded. serial_out=1 from the next edge.
//  Capacity: FIFO_DEPTH words in the FIFO plus 1 word in the shifter.
// TESTING  (CLOCK_FREQ=1000, BAUD_RATE=100 -> 10 clk/bit)
//  1. 8N1 mode, push 0xA5 while idle.
//     -> serial_out sequence 0,1,0,1,0,0,1,0,1,1, with each level held 10 clk.
//     -> tx_busy high for 100 clk; the line then idles at 1.
//  2. PARITY=2, push 0xA5 -> parity bit 0 (0xA5 has four ones). PARITY=1, push 0xA5 -> parity bit 1.
//     -> Frame is 110 clk in both cases.
//  3. Push 0x01 then 0x02 on consecutive cycles.
//     -> Two frames are contiguous: stop bit of frame 1 is followed immediately by the start bit of frame 2.
//     -> Line is busy for 200 clk total.
//  4. FIFO_DEPTH=4, hold data_in_valid with words 0..5 while the line is idle.
//     -> Exactly 5 words are accepted, then data_in_ready=0 and fifo_count=4.
//     -> data_in_ready reasserts 1 clk after the word-1 pop.
//  5. Assert reset at clk 35 of frame 1 with 2 words queued.
//     -> serial_out=1, fifo_count=0, tx_busy=0 on the next edge.
//     -> No further frames are sent.
//  6. DATA_BITS=7, STOP_BITS=2, push 7'h55.
//     -> serial_out sequence 0,1,0,1,0,1,0,1,1,1: 100 clk total, ending with 20 clk of high.

Source files
------------

// File: rtl/uart_tx_framed.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_framed
// Description : Buffered UART transmitter. Bytes enter a small FIFO through a
//               ready/valid port and are serialised LSB-first with a frame
//               format (data bits, parity, stop bits) fixed at elaboration.
//               Frames are sent back-to-back with no idle gap.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_framed #(
    parameter int CLOCK_FREQ = 125_000_000,
    parameter int BAUD_RATE  = 115_200,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic [DATA_BITS-1:0]                 data_in,
    input  logic                                 data_in_valid,
    output logic                                 data_in_ready,
    output logic                                 serial_out,
    output logic                                 tx_busy,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]      fifo_count
);

    localparam int c_SET    = CLOCK_FREQ / BAUD_RATE;
    localparam int c_CNT_W  = $clog2(c_SET);
    localparam int c_IDX_W  = $clog2(DATA_BITS);
    localparam int c_PTR_W  = $clog2(FIFO_DEPTH);
    localparam int c_FCNT_W = $clog2(FIFO_DEPTH + 1);

    localparam logic [c_CNT_W-1:0]  c_BIT_LAST  = c_CNT_W'(c_SET - 1);
    localparam logic [c_CNT_W-1:0]  c_CNT_ONE   = c_CNT_W'(1);
    localparam logic [c_IDX_W-1:0]  c_IDX_LAST  = c_IDX_W'(DATA_BITS - 1);
    localparam logic [c_IDX_W-1:0]  c_IDX_ONE   = c_IDX_W'(1);
    localparam logic [c_PTR_W-1:0]  c_PTR_ONE   = c_PTR_W'(1);
    localparam logic [c_FCNT_W-1:0] c_FCNT_ONE  = c_FCNT_W'(1);
    localparam logic [c_FCNT_W-1:0] c_FULL      = c_FCNT_W'(FIFO_DEPTH);
    localparam logic                c_STOP_LAST = (STOP_BITS == 2);
    localparam logic                c_PAR_ODD   = (PARITY == 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    // FIFO storage and bookkeeping
    logic [DATA_BITS-1:0] r_mem [FIFO_DEPTH];
    logic [c_PTR_W-1:0]   r_wr_ptr;
    logic [c_PTR_W-1:0]   r_rd_ptr;
    logic [c_FCNT_W-1:0]  r_count;
    logic                 w_push;
    logic                 w_pop;
    logic [DATA_BITS-1:0] w_head;

    // Shifter state
    state_t               r_state;
    state_t               w_state_next;
    logic [c_CNT_W-1:0]   r_bit_cnt;
    logic [c_CNT_W-1:0]   w_bit_cnt_next;
    logic [c_IDX_W-1:0]   r_idx;
    logic [c_IDX_W-1:0]   w_idx_next;
    logic                 r_stop_idx;
    logic                 w_stop_next;
    logic [DATA_BITS-1:0] r_shift;
    logic [DATA_BITS-1:0] w_shift_next;
    logic                 r_parity;
    logic                 w_parity_next;
    logic                 r_serial;
    logic                 w_serial_next;
    logic                 r_busy;
    logic                 w_bit_last;

    // Ready comes from the registered count only, so a pop never frees a slot
    // in the same cycle.
    assign data_in_ready = (r_count != c_FULL);
    assign w_push        = data_in_valid && data_in_ready;
    assign w_head        = r_mem[r_rd_ptr];
    assign w_bit_last    = (r_bit_cnt == c_BIT_LAST);
    assign fifo_count    = r_count;
    assign serial_out    = r_serial;
    assign tx_busy       = r_busy;

    // FIFO payload write; storage needs no reset since pointers gate it
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= data_in;
        end
    end

    // FIFO pointers and occupancy count
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_FCNT_ONE;
                2'b01:   r_count <= r_count - c_FCNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    // Shifter state register plus registered line/busy outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_bit_cnt  <= '0;
            r_idx      <= '0;
            r_stop_idx <= 1'b0;
            r_shift    <= '0;
            r_parity   <= 1'b0;
            r_serial   <= 1'b1;
            r_busy     <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_bit_cnt  <= w_bit_cnt_next;
            r_idx      <= w_idx_next;
            r_stop_idx <= w_stop_next;
            r_shift    <= w_shift_next;
            r_parity   <= w_parity_next;
            r_serial   <= w_serial_next;
            r_busy     <= (w_state_next != S_IDLE);
        end
    end

    // Next-state, pop and next line level; the line is driven from the next
    // state so it changes on the same edge as the state does
    always_comb begin
        w_state_next   = r_state;
        w_bit_cnt_next = r_bit_cnt + c_CNT_ONE;
        w_idx_next     = r_idx;
        w_stop_next    = r_stop_idx;
        w_shift_next   = r_shift;
        w_parity_next  = r_parity;
        w_pop          = 1'b0;
        w_serial_next  = 1'b1;

        case (r_state)
            S_IDLE: begin
                w_bit_cnt_next = '0;
                if (r_count != '0) begin
                    w_pop         = 1'b1;
                    w_shift_next  = w_head;
                    w_parity_next = (^w_head) ^ c_PAR_ODD;
                    w_state_next  = S_START;
                end
            end
            S_START: begin
                if (w_bit_last) begin
                    w_state_next   = S_DATA;
                    w_bit_cnt_next = '0;
                    w_idx_next     = '0;
                end
            end
            S_DATA: begin
                if (w_bit_last) begin
                    w_bit_cnt_next = '0;
                    w_shift_next   = r_shift >> 1;
                    if (r_idx == c_IDX_LAST) begin
                        w_state_next = (PARITY != 0) ? S_PARITY : S_STOP;
                        w_stop_next  = 1'b0;
                    end else begin
                        w_idx_next = r_idx + c_IDX_ONE;
                    end
                end
            end
            S_PARITY: begin
                if (w_bit_last) begin
                    w_state_next   = S_STOP;
                    w_bit_cnt_next = '0;
                    w_stop_next    = 1'b0;
                end
            end
            S_STOP: begin
                if (w_bit_last) begin
                    w_bit_cnt_next = '0;
                    if (r_stop_idx == c_STOP_LAST) begin
                        // Chain straight into the next frame when work is queued
                        if (r_count != '0) begin
                            w_pop         = 1'b1;
                            w_shift_next  = w_head;
                            w_parity_next = (^w_head) ^ c_PAR_ODD;
                            w_state_next  = S_START;
                        end else begin
                            w_state_next = S_IDLE;
                        end
                    end else begin
                        w_stop_next = 1'b1;
                    end
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase

        case (w_state_next)
            S_START:  w_serial_next = 1'b0;
            S_DATA:   w_serial_next = w_shift_next[0];
            S_PARITY: w_serial_next = w_parity_next;
            default:  w_serial_next = 1'b1;
        endcase
    end

endmodule
`default_nettype wire
